// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl_pkg
// Brief    : Shared RAM geometry and controller state encoding for mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam int MEM_ADDR_W = 6;
    localparam int MEM_DATA_W = 16;
    // Wide enough for RD_LAT-1 over the legal RD_LAT range 1..4
    localparam int LAT_CNT_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_VF_WAIT = 3'd3,
        ST_RESP    = 3'd4
    } mem_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lat_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lat_cnt
// Brief    : Loadable down-counter that parks at zero; flags zero for the FSM.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lat_cnt #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Single-request initiator for the memoram synchronous RAM.
//            Define MEM_CTRL_VERIFY_EN to add write read-back verification.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int RD_LAT = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    mem_ctrl_state_t r_state;
    mem_ctrl_state_t w_next_state;
    logic            w_accept;
    logic            w_cnt_load;
    logic            w_lat_zero;
    logic            w_capture;

    assign w_accept   = req_valid && req_ready;
    // Reloaded on every accept and on leaving WRITE, so both wait states share it
    assign w_cnt_load = ((r_state == ST_IDLE) && req_valid) || (r_state == ST_WRITE);

    mem_lat_cnt #(
        .WIDTH (LAT_CNT_W)
    ) u_lat_cnt (
        .clk      (Clock),
        .rst      (Reset),
        .load     (w_cnt_load),
        .load_val (LAT_LOAD),
        .zero     (w_lat_zero)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = req_we ? ST_WRITE : ST_RD_WAIT;
                end
            end
`ifdef MEM_CTRL_VERIFY_EN
            ST_WRITE:   w_next_state = ST_VF_WAIT;
`else
            ST_WRITE:   w_next_state = ST_RESP;
`endif
            ST_RD_WAIT,
            ST_VF_WAIT: begin
                if (w_lat_zero) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == ST_IDLE) && !Reset;
        busy      = (r_state != ST_IDLE);
        rsp_valid = (r_state == ST_RESP);
        w_capture = ((r_state == ST_RD_WAIT) || (r_state == ST_VF_WAIT)) && w_lat_zero;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            mem_wren <= w_accept && req_we;
            if (w_accept) begin
                mem_address <= req_addr;
                mem_data    <= req_wdata;
            end
            if (w_capture) begin
                rsp_rdata <= mem_q;
            end
        end
    end

`ifdef MEM_CTRL_VERIFY_EN
    logic r_err;

    // mem_data still holds the written word during the read-back
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (w_capture) begin
            r_err <= (r_state == ST_VF_WAIT) && (mem_q != mem_data);
        end
    end

    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Self-checking bench for mem_ctrl against a RAM model and a
//            behavioural memory image. Honors MEM_CTRL_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int AW     = MEM_ADDR_W;
    localparam int DW     = MEM_DATA_W;
    localparam int RD_LAT = 2;
`ifdef MEM_CTRL_VERIFY_EN
    localparam bit VF = 1'b1;
`else
    localparam bit VF = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    always #5 Clock = ~Clock;

    mem_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // memoram: registered address, q valid the cycle after the address edge
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_r = '0;
    logic          ram_clr = 1'b1;
    logic          force_zero = 1'b0;

    always @(posedge Clock) begin
        if (ram_clr) begin
            for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
        end else if (mem_wren) begin
            ram[mem_address] <= mem_data;
        end
        ram_addr_r <= mem_address;
    end
    assign mem_q = force_zero ? '0 : ram[ram_addr_r];

    // Reference image and bookkeeping
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] last_rdata = '0;
    logic [DW-1:0] rsp_log [0:255];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;

    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
    end

    always @(negedge Clock) begin
        if (rsp_valid === 1'b1) begin
            rsp_log[rsp_cnt % 256] <= rsp_rdata;
            rsp_cnt <= rsp_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a request and returns just after its accept edge (or on timeout)
    task automatic accept_req(input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, output bit ok);
        int n;
        @(negedge Clock);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (ok) begin
            @(posedge Clock);
            #1;
        end
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic do_req(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit fz, input string nm);
        int n, lat_exp;
        bit ok, seen, wren_bad, hs_bad;
        logic [DW-1:0] rd_exp;
        logic err_exp;
        if (we) begin
            ref_mem[addr] = data;
            lat_exp = VF ? RD_LAT + 1 : 1;
            rd_exp  = VF ? (fz ? '0 : data) : last_rdata;
            err_exp = VF && fz && (data != '0);
        end else begin
            lat_exp = RD_LAT;
            rd_exp  = ref_mem[addr];
            err_exp = 1'b0;
        end
        force_zero = fz;
        accept_req(we, addr, data, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s accept: req_ready never 1 within 50 cycles", nm);
            force_zero = 1'b0;
            return;
        end
        total++;
        if (mem_wren !== we || mem_address !== addr || mem_data !== data) begin
            bad++;
            $display("FAIL %s ram_drive: wren=%b addr=%h data=%h, required wren=%b addr=%h data=%h",
                     nm, mem_wren, mem_address, mem_data, we, addr, data);
        end
        seen = 0; wren_bad = 0; hs_bad = 0; n = 0;
        while (!seen && n < 20) begin
            @(posedge Clock);
            #1;
            n++;
            if (mem_wren !== 1'b0) wren_bad = 1;
            if (busy !== 1'b1 || req_ready !== 1'b0) hs_bad = 1;
            if (rsp_valid === 1'b1) seen = 1;
        end
        total++;
        if (!seen || n != lat_exp) begin
            bad++;
            $display("FAIL %s latency: got %0d (seen=%b), required %0d", nm, n, seen, lat_exp);
        end
        total++;
        if (rsp_rdata !== rd_exp) begin
            bad++;
            $display("FAIL %s rdata: got %h, required %h", nm, rsp_rdata, rd_exp);
        end
        total++;
        if (rsp_err !== err_exp) begin
            bad++;
            $display("FAIL %s err: got %b, required %b", nm, rsp_err, err_exp);
        end
        total++;
        if (wren_bad || hs_bad) begin
            bad++;
            $display("FAIL %s in_flight: wren_high=%b ready_busy_bad=%b, required 0 0", nm, wren_bad, hs_bad);
        end
        last_rdata = rd_exp;
        @(posedge Clock);
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s return_idle: rsp_valid=%b busy=%b ready=%b, required 0 0 1",
                     nm, rsp_valid, busy, req_ready);
        end
        force_zero = 1'b0;
    endtask

    task automatic test_reset;
        bit wren_seen;
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        total++;
        if ({mem_address, mem_data, mem_wren, rsp_valid, rsp_rdata, rsp_err, busy, req_ready} !== '0) begin
            bad++;
            $display("FAIL reset_values: addr=%h data=%h wren=%b rv=%b rd=%h err=%b busy=%b ready=%b, required all 0",
                     mem_address, mem_data, mem_wren, rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
        end
        @(negedge Clock);
        Reset = 1'b0;
        ram_clr = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1 0", req_ready, busy);
        end
        wren_seen = 0;
        repeat (4) begin
            @(posedge Clock);
            #1;
            if (mem_wren !== 1'b0) wren_seen = 1;
        end
        total++;
        if (wren_seen) begin
            bad++;
            $display("FAIL idle_wren: mem_wren went high while idle, required 0");
        end
    endtask

    task automatic test_write_read;
        do_req(1'b1, 6'd0, 16'h0001, 1'b0, "wr_a0");
        do_req(1'b0, 6'd0, 16'h0000, 1'b0, "rd_a0");
    endtask

    task automatic test_back_to_back(input bit we, input logic [DW-1:0] d0, d1, d2, input string nm);
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] dat [3];
        logic [DW-1:0] exp;
        int t [3];
        int acc0, r0, n, gap_exp;
        addrs = '{6'd5, 6'd10, 6'd63};
        dat   = '{d0, d1, d2};
        gap_exp = we ? (VF ? RD_LAT + 3 : 3) : RD_LAT + 2;
        acc0 = acc_cnt;
        r0   = rsp_cnt;
        @(negedge Clock);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_we = we; req_addr = addrs[i]; req_wdata = dat[i];
            n = 0;
            while (req_ready !== 1'b1 && n < 50) begin
                @(negedge Clock);
                n++;
            end
            @(posedge Clock);
            #1;
            t[i] = cyc;
        end
        req_valid = 1'b0;
        repeat (gap_exp + 2) @(posedge Clock);
        #1;
        total++;
        if (acc_cnt - acc0 != 3 || rsp_cnt - r0 != 3) begin
            bad++;
            $display("FAIL %s counts: accepts=%0d responses=%0d, required 3 3", nm, acc_cnt - acc0, rsp_cnt - r0);
        end
        total++;
        if (t[1] - t[0] != gap_exp || t[2] - t[1] != gap_exp) begin
            bad++;
            $display("FAIL %s spacing: gaps %0d %0d, required %0d", nm, t[1] - t[0], t[2] - t[1], gap_exp);
        end
        for (int i = 0; i < 3; i++) begin
            if (we) begin
                ref_mem[addrs[i]] = dat[i];
                exp = VF ? dat[i] : last_rdata;
            end else begin
                exp = ref_mem[addrs[i]];
            end
            last_rdata = exp;
            total++;
            if (rsp_log[(r0 + i) % 256] !== exp) begin
                bad++;
                $display("FAIL %s rdata[%0d]: got %h, required %h", nm, i, rsp_log[(r0 + i) % 256], exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] a;
        bit ok;
        int r0;
        a = AW'($urandom);
        accept_req(1'b0, a, '0, ok);
        r0 = rsp_cnt;
        total++;
        if (!ok || busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid accept: ok=%b busy=%b, required 1 1", ok, busy);
        end
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        total++;
        if (busy !== 1'b0 || mem_wren !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid abort: busy=%b wren=%b rv=%b ready=%b, required 0 0 0 0",
                     busy, mem_wren, rsp_valid, req_ready);
        end
        @(negedge Clock);
        Reset = 1'b0;
        repeat (RD_LAT + 3) @(posedge Clock);
        #1;
        total++;
        if (rsp_cnt != r0) begin
            bad++;
            $display("FAIL rst_mid no_rsp: %0d responses seen, required 0", rsp_cnt - r0);
        end
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || mem_address !== '0 || rsp_rdata !== '0) begin
            bad++;
            $display("FAIL rst_mid idle: busy=%b ready=%b addr=%h rd=%h, required 0 1 0 0",
                     busy, req_ready, mem_address, rsp_rdata);
        end
        last_rdata = '0;
    endtask

    task automatic test_ignore_during_rd;
        logic [AW-1:0] a;
        bit ok, stable;
        a = 6'd10;
        accept_req(1'b0, a, '0, ok);
        stable = ok;
        for (int j = 1; j <= RD_LAT; j++) begin
            req_valid = j[0];
            req_we    = 1'($urandom);
            req_addr  = a ^ AW'($urandom_range(1, (1<<AW) - 1));
            req_wdata = DW'($urandom);
            @(posedge Clock);
            #1;
            if (mem_address !== a || mem_wren !== 1'b0) stable = 0;
        end
        req_valid = 1'b0;
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL ignore addr_hold: mem_address=%h wren=%b, required %h 0", mem_address, mem_wren, a);
        end
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[a]) begin
            bad++;
            $display("FAIL ignore rsp: rv=%b rd=%h, required 1 %h", rsp_valid, rsp_rdata, ref_mem[a]);
        end
        last_rdata = ref_mem[a];
        @(posedge Clock);
        #1;
        total++;
        if (busy !== 1'b0 || mem_address !== a) begin
            bad++;
            $display("FAIL ignore after: busy=%b addr=%h, required 0 %h", busy, mem_address, a);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? '1 : '0;
            else a = AW'($urandom);
            do_req(1'($urandom), a, DW'($urandom), 1'b0, "rand");
        end
    endtask

`ifdef MEM_CTRL_VERIFY_EN
    task automatic test_verify;
        do_req(1'b1, 6'd7, 16'h00FF, 1'b1, "vf_forced");
        do_req(1'b1, 6'd7, 16'h00FF, 1'b0, "vf_clean");
        do_req(1'b0, 6'd7, 16'h0000, 1'b0, "vf_readback");
    endtask
`endif

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        test_reset;
        test_write_read;
        test_back_to_back(1'b1, 16'hAAAA, 16'h1234, 16'hFFFF, "b2b_wr");
        test_back_to_back(1'b0, 16'h0000, 16'h0000, 16'h0000, "b2b_rd");
        test_reset_mid;
        test_ignore_during_rd;
        test_random;
`ifdef MEM_CTRL_VERIFY_EN
        test_verify;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
